// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF  = 5;
    localparam int CNT_W_DEF       = 16;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_re,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs2_re,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_addr,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_re && (id_rs1_addr == ex_write_addr);
    assign rs2_hit = id_rs2_re && (id_rs2_addr == ex_write_addr);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard = ex_mem_read && (ex_write_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// data-memory wait handling with a timeout watchdog and a stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic                  id_rs1_re,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs2_re,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_addr,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_flush,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hazard_state_t     state;
    hazard_state_t     next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_wait;
    logic              load_use;
    pipe_ctrl_t        ctrl;

    assign mem_wait = mem_req && !mem_ready;

    load_use_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_load_use (
        .id_rs1_addr  (id_rs1_addr),
        .id_rs1_re    (id_rs1_re),
        .id_rs2_addr  (id_rs2_addr),
        .id_rs2_re    (id_rs2_re),
        .ex_mem_read  (ex_mem_read),
        .ex_write_addr(ex_write_addr),
        .hazard       (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:      if (mem_wait) next_state = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (!mem_wait)                  next_state = ST_RUN;
                else if (wait_cnt == WAIT_LAST) next_state = ST_ERR;
            end
            ST_ERR:      next_state = ST_ERR;
            default:     next_state = ST_RUN;
        endcase
    end

    // Priority: reset > error > memory wait > taken branch > load-use
    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (state == ST_ERR || mem_wait) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end else if (load_use) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != ST_MEM_WAIT) wait_cnt <= '0;
        else                             wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                                   stall_cnt <= '0;
        else if (ctrl.pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end

    assign pc_stall     = ctrl.pc_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_stall = ctrl.ex_mem_stall;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_err      = (state == ST_ERR) && !rst;
    assign stall_cycles = rst ? '0 : stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives two differently-parameterised sequencers with directed and random
// stimulus and checks both against a rule-level model of the hazard policy.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr;
    logic       id_rs1_re;
    logic [4:0] id_rs2_addr;
    logic       id_rs2_re;
    logic       ex_mem_read;
    logic [4:0] ex_write_addr;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;

    logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall;
    logic        a_id_ex_flush, a_ex_mem_stall, a_mem_wb_flush, a_mem_err;
    logic [15:0] a_stall_cycles;
    logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_stall;
    logic        b_id_ex_flush, b_ex_mem_stall, b_mem_wb_flush, b_mem_err;
    logic [3:0]  b_stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    int tmo[2]       = '{64, 4};
    int cmax[2]      = '{65535, 15};
    int m_consec[2]  = '{0, 0};
    bit m_err[2]     = '{1'b0, 1'b0};
    int m_cnt[2]     = '{0, 0};

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs1_re(id_rs1_re),
        .id_rs2_addr(id_rs2_addr), .id_rs2_re(id_rs2_re),
        .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
        .id_ex_stall(a_id_ex_stall), .id_ex_flush(a_id_ex_flush),
        .ex_mem_stall(a_ex_mem_stall), .mem_wb_flush(a_mem_wb_flush),
        .mem_err(a_mem_err), .stall_cycles(a_stall_cycles)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs1_re(id_rs1_re),
        .id_rs2_addr(id_rs2_addr), .id_rs2_re(id_rs2_re),
        .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
        .id_ex_stall(b_id_ex_stall), .id_ex_flush(b_id_ex_flush),
        .ex_mem_stall(b_ex_mem_stall), .mem_wb_flush(b_mem_wb_flush),
        .mem_err(b_mem_err), .stall_cycles(b_stall_cycles)
    );

    // Expected controls as {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, mem_wb_flush, mem_err}, straight from the policy rules
    function automatic logic [7:0] modelCtrl(int k);
        bit wait_now = mem_req && !mem_ready;
        bit hazard   = ex_mem_read && (ex_write_addr != 5'd0) &&
                       ((id_rs1_re && id_rs1_addr == ex_write_addr) ||
                        (id_rs2_re && id_rs2_addr == ex_write_addr));
        if (rst)             return 8'b0010_1010;
        if (m_err[k])        return 8'b1101_0111;
        if (wait_now)        return 8'b1101_0110;
        if (ex_branch_taken) return 8'b0010_1000;
        if (hazard)          return 8'b1100_1000;
        return 8'b0000_0000;
    endfunction

    task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic rs1_re,
                                 input logic [4:0] rs2, input logic rs2_re,
                                 input logic ld, input logic [4:0] wa, input logic br,
                                 input logic req, input logic rdy);
        rst             = r;
        id_rs1_addr     = rs1;
        id_rs1_re       = rs1_re;
        id_rs2_addr     = rs2;
        id_rs2_re       = rs2_re;
        ex_mem_read     = ld;
        ex_write_addr   = wa;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp_ctrl[2];
        logic [7:0] obs_ctrl;
        int         exp_cnt;
        int         obs_cnt;
        bit         wait_now;
        #2;
        wait_now = mem_req && !mem_ready;
        for (int k = 0; k < 2; k++) begin
            exp_ctrl[k] = modelCtrl(k);
            exp_cnt     = rst ? 0 : m_cnt[k];
            if (k == 0) begin
                obs_ctrl = {a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_stall,
                            a_id_ex_flush, a_ex_mem_stall, a_mem_wb_flush, a_mem_err};
                obs_cnt  = int'(a_stall_cycles);
            end else begin
                obs_ctrl = {b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_stall,
                            b_id_ex_flush, b_ex_mem_stall, b_mem_wb_flush, b_mem_err};
                obs_cnt  = int'(b_stall_cycles);
            end
            compared++;
            assert (obs_ctrl === exp_ctrl[k]) else begin
                mismatched++;
                $error("[TB] FAIL %s ctrl dut%0d: observed %b expected %b",
                       tag, k, obs_ctrl, exp_ctrl[k]);
            end
            compared++;
            assert (obs_cnt === exp_cnt) else begin
                mismatched++;
                $error("[TB] FAIL %s stall_cycles dut%0d: observed %0d expected %0d",
                       tag, k, obs_cnt, exp_cnt);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_err[k]    = 1'b0;
                m_consec[k] = 0;
                m_cnt[k]    = 0;
            end else begin
                if (exp_ctrl[k][7] && m_cnt[k] < cmax[k]) m_cnt[k]++;
                if (!m_err[k]) begin
                    if (wait_now) begin
                        m_consec[k]++;
                        if (m_consec[k] == tmo[k] + 1) m_err[k] = 1'b1;
                    end else begin
                        m_consec[k] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("reset0");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("reset1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("idle");

        applyStimulus(0, 5, 1, 1, 1, 1, 5, 0, 0, 0); checkOutput("lu_rs1");
        applyStimulus(0, 5, 1, 1, 1, 0, 0, 0, 0, 0); checkOutput("lu_bubble");
        applyStimulus(0, 0, 1, 0, 1, 1, 0, 0, 0, 0); checkOutput("lu_x0");
        applyStimulus(0, 2, 0, 7, 1, 1, 7, 0, 0, 0); checkOutput("lu_rs2");
        applyStimulus(0, 7, 0, 3, 1, 1, 7, 0, 0, 0); checkOutput("lu_rs1_unread");

        applyStimulus(0, 5, 1, 1, 1, 1, 5, 1, 0, 0); checkOutput("branch_lu");

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("memwait3");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("memwait3_ready");

        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); checkOutput("branch_in_wait");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); checkOutput("branch_release");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("timeout_wait");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); checkOutput("err_stuck0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("err_stuck1");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("wait_before_rst");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("rst_mid_wait");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("after_rst");

        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 9, 1, 0, 0, 1, 9, 0, 0, 0); checkOutput("saturate");
        end
        compared++;
        assert (b_stall_cycles === 4'd15) else begin
            mismatched++;
            $error("[TB] FAIL sat_value: observed %0d expected 15", b_stall_cycles);
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                          5'($urandom_range(0, 3)), 1'($urandom),
                          5'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                          5'($urandom_range(0, 3)),
                          ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
